// File: rtl/reg_ring_master.sv
// reg_ring_master
//   Initiator at the head of the UDP register ring. It turns one command word
//   (read or write, address, write data) into a single ring request. It then
//   waits for that request to come back around the ring and hands the result
//   to the command requester.
//
//   Ports:
//     clk, reset             clock and synchronous active-high reset
//     cmd_*                  command request from the host sequencer (valid/ready)
//     rsp_*                  response to the host sequencer (valid/ready),
//                            with ack and timeout flags
//     stray_count            saturating count of returns that matched nothing
//     reg_*_out              request driven into the first ring module
//     reg_*_in               return taken from the last ring module
//
//   Only one transaction is ever outstanding. Every output is registered.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_ring_master #(
    parameter int                           UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = UDP_REG_SRC_WIDTH'(1),
    parameter int unsigned                  TIMEOUT_CYCLES    = 255
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_rd_wr_L,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  cmd_wdata,

    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]  rsp_data,
    output logic                             rsp_ack,
    output logic                             rsp_timeout,
    output logic [15:0]                      stray_count,

    output logic                             reg_req_out,
    output logic                             reg_ack_out,
    output logic                             reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out,

    input  logic                             reg_req_in,
    input  logic                             reg_ack_in,
    input  logic                             reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in
);

    localparam int AW = `UDP_REG_ADDR_WIDTH;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;

    // The counter is cleared in ISSUE and advances once per WAIT cycle. When it
    // is about to wrap past this value, WAIT has lasted TIMEOUT_CYCLES cycles.
    localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEAD_DEAD);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          next_state;

    logic            lat_rd_wr_L;
    logic [AW-1:0]   lat_addr;
    logic [15:0]     timeout_count;

    logic            accept;
    logic            match;
    logic            timed_out;
    logic            release_rsp;

    // Event decode. A return only counts as a match while we are waiting for
    // it. Anything else on reg_req_in is stray.
    always_comb begin
        accept      = 1'b0;
        match       = 1'b0;
        timed_out   = 1'b0;
        release_rsp = 1'b0;

        accept = (state == IDLE) && cmd_valid && cmd_ready;

        match = (state == WAIT) && reg_req_in
                && (reg_src_in == SRC_ID)
                && (reg_addr_in == lat_addr)
                && (reg_rd_wr_L_in == lat_rd_wr_L);

        timed_out   = (state == WAIT) && (timeout_count == TIMEOUT_LAST);
        release_rsp = (state == RESP) && rsp_valid && rsp_ready;
    end

    // Next-state logic. If a match and a timeout happen in the same cycle,
    // both lead to RESP. The registered response fields below give the match
    // priority.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (match || timed_out) next_state = RESP;
            RESP:    if (release_rsp) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs and the transaction context.
    // The ring request fields are loaded on the accepting edge. They are
    // therefore visible for exactly the one ISSUE cycle, and are forced back
    // to zero on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready       <= 1'b1;
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
            lat_rd_wr_L     <= 1'b0;
            lat_addr        <= '0;
            timeout_count   <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_ack         <= 1'b0;
            rsp_timeout     <= 1'b0;
            stray_count     <= '0;
        end else begin
            cmd_ready <= (next_state == IDLE);

            reg_req_out     <= accept;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= accept && cmd_rd_wr_L;
            reg_addr_out    <= accept ? cmd_addr : '0;
            reg_data_out    <= (accept && !cmd_rd_wr_L) ? cmd_wdata : '0;
            reg_src_out     <= accept ? SRC_ID : '0;

            if (accept) begin
                lat_rd_wr_L <= cmd_rd_wr_L;
                lat_addr    <= cmd_addr;
            end

            if (state == ISSUE) begin
                timeout_count <= '0;
            end else if (state == WAIT) begin
                timeout_count <= timeout_count + 16'd1;
            end

            // The response fields hold their last value outside RESP.
            // Only rsp_valid qualifies them.
            if (match) begin
                rsp_data    <= reg_data_in;
                rsp_ack     <= reg_ack_in;
                rsp_timeout <= 1'b0;
            end else if (timed_out) begin
                rsp_data    <= TIMEOUT_DATA;
                rsp_ack     <= 1'b0;
                rsp_timeout <= 1'b1;
            end

            rsp_valid <= (next_state == RESP);

            if (reg_req_in && !match && (stray_count != 16'hFFFF)) begin
                stray_count <= stray_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/reg_ring_master.md
Name: reg_ring_master

Overview:
- Initiator end of the UDP register ring. It converts single-word command requests into ring transactions: read or write, with address, data and source tag.
- It sits at the head of the ring, ahead of the generic_regs responders in the pipeline and datapath modules.
- It drives reg_*_out into the first ring module and takes reg_*_in from the last ring module.
- It matches each returning transaction to its command, waits for it with a timeout, and hands the result back to the command requester (a host/test sequencer loading instruction and data memory).

Parameters:
- UDP_REG_SRC_WIDTH, 2, width of the reg_src field.
- SRC_ID, 2'd1, source tag stamped on every issued request; returns are matched on it.
- TIMEOUT_CYCLES, 255, WAIT-state cycles before a transaction is abandoned (1..65535).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_rd_wr_L  in  1  1 = read, 0 = write
- cmd_addr  in  `UDP_REG_ADDR_WIDTH  register address
- cmd_wdata  in  `CPCI_NF2_DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  requester accepts the response
- rsp_data  out  `CPCI_NF2_DATA_WIDTH  read data (returned data for writes)
- rsp_ack  out  1  a ring module acknowledged
- rsp_timeout  out  1  no matching return within TIMEOUT_CYCLES
- stray_count  out  16  count of unmatched returns, saturating
- reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring request to the head
- reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring request to the head
- reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring request to the head
- reg_src_out  out  UDP_REG_SRC_WIDTH  ring request to the head
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring return from the tail
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring return from the tail
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring return from the tail
- reg_src_in  in  UDP_REG_SRC_WIDTH  ring return from the tail

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on the port named reset.
- Reset values:
  - State = IDLE.
  - cmd_ready = 1.
  - All reg_*_out = 0.
  - rsp_valid, rsp_ack, rsp_timeout = 0; rsp_data = 0.
  - stray_count = 0; timeout counter = 0.
- Reset mid-transaction drops the outstanding request silently. A return arriving later is counted as stray.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_rd_wr_L, cmd_addr and cmd_wdata; go to ISSUE next cycle.
- ISSUE (exactly 1 cycle):
  - reg_req_out = 1, reg_ack_out = 0, reg_rd_wr_L_out / reg_addr_out = latched values.
  - reg_data_out = latched wdata for writes, 0 for reads.
  - reg_src_out = SRC_ID.
  - Clear the timeout counter; go to WAIT.
- ISSUE exit: in every cycle outside ISSUE, reg_req_out = 0 and the other reg_*_out return to 0.
- WAIT:
  - Counter increments each cycle.
  - A matching return is reg_req_in = 1 with reg_src_in == SRC_ID, reg_addr_in == latched addr and reg_rd_wr_L_in == latched rd_wr_L.
  - On a match: rsp_data = reg_data_in, rsp_ack = reg_ack_in, rsp_timeout = 0; go to RESP.
  - When the counter reaches TIMEOUT_CYCLES with no match: rsp_ack = 0, rsp_timeout = 1, rsp_data = 32'hDEAD_DEAD; go to RESP.
  - If a match and the timeout occur in the same cycle, the match wins.
- RESP:
  - rsp_valid = 1, held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE next cycle.
  - cmd_ready = 0 in ISSUE, WAIT and RESP. Exactly one outstanding transaction.
- Stray returns: any reg_req_in = 1 that is not a match (wrong src/addr/type, or any return outside WAIT) increments stray_count, saturating at 16'hFFFF. The return is otherwise dropped.
- A return with reg_ack_in = 0 is a valid match: the address was unclaimed. It gives rsp_ack = 0 and rsp_timeout = 0.
- Latency: command accept to reg_req_out is 1 cycle. Matching return to rsp_valid is 1 cycle.

Test Plan:
- Write: cmd write addr=0x000400, data=0x0000_0203. Ring loopback with 3-cycle delay sets ack=1. Expect:
  - reg_req_out pulses exactly 1 cycle, with src=1 and rd_wr_L=0.
  - rsp_valid 4 cycles after ISSUE, rsp_ack=1, rsp_timeout=0.
- Read: cmd read addr=0x000404. Loopback returns ack=1, data=0x1234_5678. Expect rsp_data=0x1234_5678, rsp_ack=1, and reg_data_out=0 during ISSUE.
- Timeout: TIMEOUT_CYCLES=8, no return. Expect:
  - rsp_timeout=1, rsp_data=0xDEADDEAD, rsp_valid 9 cycles after ISSUE.
  - A late return 5 cycles afterwards gives stray_count=1.
- Backpressure: hold rsp_ready=0 for 10 cycles. Expect rsp_* stable, cmd_ready=0, and a cmd_valid presented meanwhile not accepted. Raise rsp_ready: IDLE next cycle, command accepted the cycle after.
- Mismatch and unclaimed: return with src=2 during WAIT gives stray_count+1 and the block keeps waiting. Then a matching return with ack=0 gives rsp_ack=0, rsp_timeout=0.
- Reset mid-WAIT: assert reset for 1 cycle. Expect all outputs at reset values, cmd_ready=1. The subsequent matching return is counted as stray.
